// File: rtl/hls_deadlock_mon_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor.
package hls_deadlock_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2,
    LATCHED = 2'd3
  } mon_state_t;

  localparam int TS_W = 32;

  // Counter width able to hold the value THRESHOLD itself.
  function automatic int cnt_w(input int threshold);
    return (threshold < 1) ? 1 : $clog2(threshold + 1);
  endfunction

endpackage

// File: rtl/hls_deadlock_persist_cnt.sv
// Saturating consecutive-event counter; reached flags that the current hit
// completes a run of THRESHOLD consecutive hits.
module hls_deadlock_persist_cnt
  import hls_deadlock_mon_pkg::*;
#(
  parameter int THRESHOLD = 1,
  parameter int CW        = cnt_w(THRESHOLD)
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic hit,
  output logic reached
);

  localparam logic [CW-1:0] LIMIT = CW'(THRESHOLD);

  logic [CW-1:0] count;
  logic [CW-1:0] base;
  logic [CW:0]   base_plus;

  // restart makes this hit count as the first of a fresh run.
  assign base      = restart ? '0 : count;
  assign base_plus = {1'b0, base} + (CW+1)'(1);
  assign reached   = (base_plus >= (CW+1)'(THRESHOLD));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (!hit) begin
      count <= '0;
    end else begin
      count <= (base == LIMIT) ? LIMIT : base_plus[CW-1:0];
    end
  end

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor for one HLS dataflow instance: raw stall reduction,
// persistence filter, optional sticky latch and cause/timestamp capture.
// Define DEADLOCK_MON_TIMESTAMP_EN to build the detection cycle stamp.
module hls_deadlock_monitor_param
  import hls_deadlock_mon_pkg::*;
#(
  parameter int                N_AXIS    = 2,
  parameter int                N_IDLE    = 4,
  parameter int                N_SUB     = 1,
  parameter logic [N_AXIS-1:0] AXIS_MASK = {N_AXIS{1'b1}},
  parameter int                THRESHOLD = 1,
  parameter bit                STICKY    = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_IDLE-1:0] inst_idle_sigs,
  input  logic [N_SUB-1:0]  inst_block_sigs,
  input  logic              clear,
  output logic              block,
  output logic [N_AXIS-1:0] cause_axis,
  output logic [N_SUB-1:0]  cause_sub,
  output logic [1:0]        state,
  output logic [TS_W-1:0]   detect_cycle
);

  mon_state_t state_q, state_nxt, state_eff;
  logic       raw, reached, hit, restart, enter_blocked;

  // A fully idle instance cannot be deadlocked, whatever its stall lines say.
  assign raw = (|(axis_block_sigs & AXIS_MASK) | |inst_block_sigs) & ~(&inst_idle_sigs);

  // clear re-evaluates the current cycle as if starting from IDLE.
  assign state_eff = clear ? IDLE : state_q;
  assign hit       = raw && ((state_eff == IDLE) || (state_eff == SUSPECT));
  assign restart   = (state_eff != SUSPECT);

  hls_deadlock_persist_cnt #(
    .THRESHOLD (THRESHOLD)
  ) u_persist (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .hit     (hit),
    .reached (reached)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // NOTE: combinational blocks assign a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state_eff;
    case (state_eff)
      IDLE, SUSPECT: begin
        if (raw) state_nxt = reached ? BLOCKED : SUSPECT;
        else     state_nxt = IDLE;
      end
      BLOCKED: begin
        if (!raw) state_nxt = STICKY ? LATCHED : IDLE;
      end
      LATCHED: state_nxt = LATCHED;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    block         = (state_q == BLOCKED) || (state_q == LATCHED);
    state         = state_q;
    enter_blocked = (state_nxt == BLOCKED) && (state_eff != BLOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cause_axis <= '0;
      cause_sub  <= '0;
    end else if (enter_blocked) begin
      cause_axis <= axis_block_sigs & AXIS_MASK;
      cause_sub  <= inst_block_sigs;
    end else if (clear) begin
      cause_axis <= '0;
      cause_sub  <= '0;
    end
  end

`ifdef DEADLOCK_MON_TIMESTAMP_EN
  logic [TS_W-1:0] cycle_q;
  logic [TS_W-1:0] stamp_q;

  always_ff @(posedge clock) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + TS_W'(1);
  end

  // Stamp is the counter value seen in the first cycle block is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      stamp_q <= '0;
    end else if (enter_blocked) begin
      stamp_q <= cycle_q + TS_W'(1);
    end else if (clear) begin
      stamp_q <= '0;
    end
  end

  assign detect_cycle = stamp_q;
`else
  assign detect_cycle = '0;
`endif

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Self-checking bench: four monitor configurations share one stimulus stream
// and are compared every cycle against a run-length behavioural model.
module tb_hls_deadlock_monitor_param;

  localparam int         NI        = 4;
  localparam int         T_P [NI]  = '{1, 4, 3, 2};
  localparam bit         S_P [NI]  = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [1:0] M_P [NI]  = '{2'b11, 2'b11, 2'b11, 2'b10};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [1:0] axis  = '0;
  logic [3:0] idle  = '0;
  logic [0:0] sub   = '0;

  logic        blk    [NI];
  logic [1:0]  c_axis [NI];
  logic [0:0]  c_sub  [NI];
  logic [1:0]  st     [NI];
  logic [31:0] det    [NI];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    hls_deadlock_monitor_param #(
      .N_AXIS    (2),
      .N_IDLE    (4),
      .N_SUB     (1),
      .AXIS_MASK (M_P[g]),
      .THRESHOLD (T_P[g]),
      .STICKY    (S_P[g])
    ) u_dut (
      .clock           (clock),
      .reset           (reset),
      .axis_block_sigs (axis),
      .inst_idle_sigs  (idle),
      .inst_block_sigs (sub),
      .clear           (clear),
      .block           (blk[g]),
      .cause_axis      (c_axis[g]),
      .cause_sub       (c_sub[g]),
      .state           (st[g]),
      .detect_cycle    (det[g])
    );
  end

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] t=%0t got=%0h expected=%0h", nm, idx, $time, act, exp);
    end
  endtask

  // Model: length of the current raw run, plus a sticky latch flag.
  int          run     [NI];
  bit          latched [NI];
  bit          m_blk   [NI];
  logic [1:0]  m_caxis [NI];
  logic [0:0]  m_csub  [NI];
  logic [31:0] m_det   [NI];
  logic [31:0] ts;
  bit          m_raw, m_was_blocked, m_now;

  always @(posedge clock) begin
    if (reset) begin
      ts = '0;
      for (int i = 0; i < NI; i++) begin
        run[i] = 0; latched[i] = 1'b0; m_blk[i] = 1'b0;
        m_caxis[i] = '0; m_csub[i] = '0; m_det[i] = '0;
      end
    end else begin
      ts = ts + 32'd1;
      for (int i = 0; i < NI; i++) begin
        m_raw         = ((|(axis & M_P[i])) | sub[0]) & ~(&idle);
        m_was_blocked = m_blk[i] && !latched[i];
        if (clear) begin
          latched[i] = 1'b0;
          run[i]     = m_raw ? 1 : 0;
        end else if (!latched[i]) begin
          run[i] = m_raw ? ((run[i] < 100000) ? run[i] + 1 : run[i]) : 0;
          if (S_P[i] && m_was_blocked && !m_raw) latched[i] = 1'b1;
        end
        m_now = !latched[i] && (run[i] >= T_P[i]);
        if (m_now && !(m_was_blocked && !clear)) begin
          m_caxis[i] = axis & M_P[i];
          m_csub[i]  = sub;
          m_det[i]   = ts;
        end else if (clear) begin
          m_caxis[i] = '0;
          m_csub[i]  = '0;
          m_det[i]   = '0;
        end
        m_blk[i] = latched[i] || m_now;
      end
    end
  end

  function automatic logic [1:0] m_state(input int i);
    if (latched[i])        return 2'd3;
    if (run[i] >= T_P[i])  return 2'd2;
    if (run[i] > 0)        return 2'd1;
    return 2'd0;
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int i = 0; i < NI; i++) begin
        check("block", i, 32'(blk[i]), 32'(m_blk[i]));
        check("state", i, 32'(st[i]), 32'(m_state(i)));
        check("cause_axis", i, 32'(c_axis[i]), 32'(m_caxis[i]));
        check("cause_sub", i, 32'(c_sub[i]), 32'(m_csub[i]));
`ifdef DEADLOCK_MON_TIMESTAMP_EN
        check("detect_cycle", i, det[i], m_det[i]);
`else
        check("detect_cycle", i, det[i], 32'd0);
`endif
      end
    end
  end

  // Drive one cycle of inputs, then stand just after the sampling edge.
  task automatic step(input logic [1:0] a, input logic [3:0] id, input logic s, input logic c);
    axis  = a;
    idle  = id;
    sub   = s;
    clear = c;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    axis = '0; idle = '0; sub = '0; clear = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  int pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    repeat (2) @(posedge clock);
    #1;
    cmp_en = 1'b1;
    for (int i = 0; i < NI; i++) check("reset_block", i, 32'(blk[i]), 32'd0);
    reset = 1'b0;

    // Single-cycle stall, THRESHOLD=1: one-cycle registered response.
    step(2'b01, 4'h0, 1'b0, 1'b0);
    check("t1_block", 0, 32'(blk[0]), 32'd1);
    check("t1_cause", 0, 32'(c_axis[0]), 32'h1);
    step(2'b00, 4'h0, 1'b0, 1'b0);
    check("t1_drop", 0, 32'(blk[0]), 32'd0);
    check("t1_hold", 0, 32'(c_axis[0]), 32'h1);

    // THRESHOLD=4: gap restarts the run, fourth of the second burst detects.
    for (int k = 0; k < 8; k++) begin
      step(pat[k] != 0 ? 2'b10 : 2'b00, 4'h0, 1'b0, 1'b0);
      check("t2_block", k, 32'(blk[1]), (k == 7) ? 32'd1 : 32'd0);
    end
    step(2'b00, 4'h0, 1'b0, 1'b1);
    step(2'b00, 4'h0, 1'b0, 1'b0);

    // STICKY, THRESHOLD=3: latch survives raw dropping until clear.
    for (int k = 0; k < 3; k++) step(2'b11, 4'h0, 1'b0, 1'b0);
    check("t3_block", 2, 32'(blk[2]), 32'd1);
    check("t3_state", 2, 32'(st[2]), 32'd2);
    step(2'b00, 4'h0, 1'b0, 1'b0);
    check("t3_latched", 2, 32'(st[2]), 32'd3);
    check("t3_latched_blk", 2, 32'(blk[2]), 32'd1);
    step(2'b00, 4'h0, 1'b0, 1'b0);
    check("t3_hold", 2, 32'(st[2]), 32'd3);
    step(2'b00, 4'h0, 1'b0, 1'b1);
    check("t3_clear", 2, 32'(blk[2]), 32'd0);
    check("t3_clear_cause", 2, 32'(c_axis[2]), 32'd0);

    // Masked channel never detects; all-idle suppresses raw.
    for (int k = 0; k < 5; k++) begin
      step(2'b01, 4'h0, 1'b0, 1'b0);
      check("t4_masked", k, 32'(blk[3]), 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      step(2'b11, 4'hF, 1'b1, 1'b0);
      check("t4_idle", k, 32'(blk[0]), 32'd0);
    end
    step(2'b00, 4'h0, 1'b0, 1'b1);

    // Reset while blocked with raw high, then re-detection after THRESHOLD.
    for (int k = 0; k < 5; k++) step(2'b11, 4'h0, 1'b0, 1'b0);
    check("t5_pre", 1, 32'(blk[1]), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("t5_rst_blk", 1, 32'(blk[1]), 32'd0);
    check("t5_rst_state", 1, 32'(st[1]), 32'd0);
    check("t5_rst_cause", 1, 32'(c_axis[1]), 32'd0);
    check("t5_rst_det", 0, det[0], 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(2'b11, 4'h0, 1'b0, 1'b0);
      check("t5_redetect", k, 32'(blk[1]), (k == 4) ? 32'd1 : 32'd0);
    end

    // Timestamp: raw while the cycle counter reads 100.
    do_reset();
    for (int k = 0; k < 100; k++) step(2'b00, 4'h0, 1'b0, 1'b0);
    step(2'b01, 4'h0, 1'b0, 1'b0);
    check("t6_block", 0, 32'(blk[0]), 32'd1);
`ifdef DEADLOCK_MON_TIMESTAMP_EN
    check("t6_detect_cycle", 0, det[0], 32'd101);
`else
    check("t6_detect_cycle", 0, det[0], 32'd0);
`endif

    // Randomised traffic checked by the model.
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 499) == 0);
      axis  = 2'($urandom);
      idle  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom);
      sub   = 1'($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 19) == 0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    clear = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1;
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
